// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 key decoder: scan codes, key indices
// and the prefix-tracking FSM state type.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_F0    = 8'hF0;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_FIRE  = 8'h1A;
  localparam logic [7:0] SC_BOMB  = 8'h22;
  localparam logic [7:0] SC_SLOW  = 8'h12;
  localparam logic [7:0] SC_PAUSE = 8'h76;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_FIRE  = 3'd4;
  localparam logic [2:0] KEY_BOMB  = 3'd5;
  localparam logic [2:0] KEY_SLOW  = 3'd6;
  localparam logic [2:0] KEY_PAUSE = 3'd7;

  // Bytes that follow E1 in the Pause/Break make sequence.
  localparam logic [2:0] SKIP_LEN  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational lookup of {extended, scan code} to one of the eight game keys.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [2:0] idx
);

  always_comb begin
    hit = 1'b1;
    idx = '0;
    if (ext) begin
      case (code)
        SC_UP:    idx = KEY_UP;
        SC_DOWN:  idx = KEY_DOWN;
        SC_LEFT:  idx = KEY_LEFT;
        SC_RIGHT: idx = KEY_RIGHT;
        default:  hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_FIRE:  idx = KEY_FIRE;
        SC_BOMB:  idx = KEY_BOMB;
        SC_SLOW:  idx = KEY_SLOW;
        SC_PAUSE: idx = KEY_PAUSE;
        default:  hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the PS/2 set-2 byte stream into held-key state plus press/release
// pulses, resolving E0/F0/E1 prefixes and dropping typematic repeats.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [7:0] key_state,
  output logic [7:0] key_press,
  output logic [7:0] key_release,
  output logic       seq_err
);

  localparam int            TW  = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(PREFIX_TIMEOUT);

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_skip, w_skip_nxt;
  logic          w_evt_vld, w_evt_ext, w_evt_brk, w_seq_err;
  logic          w_hit;
  logic [2:0]    w_idx;

  logic          r_vld_p0, r_brk_p0;
  logic [2:0]    r_idx_p0;
  logic [7:0]    w_mask_p0;

  logic [7:0]    r_key_state, r_key_press, r_key_release;
  logic          r_seq_err;

  ps2_keymap u_keymap (
    .ext  (w_evt_ext),
    .code (code),
    .hit  (w_hit),
    .idx  (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_skip_nxt  = r_skip;
    w_evt_vld   = 1'b0;
    w_evt_ext   = 1'b0;
    w_evt_brk   = 1'b0;
    w_seq_err   = 1'b0;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (r_state != ST_IDLE && !code_valid) begin
      if (r_timer == TMO) begin
        w_state_nxt = ST_IDLE;
        w_skip_nxt  = '0;
        w_seq_err   = 1'b1;
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
    end

    if (code_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (code == SC_E0) begin
            w_state_nxt = ST_EXT;
          end else if (code == SC_F0) begin
            w_state_nxt = ST_BRK;
          end else if (code == SC_E1) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = SKIP_LEN;
          end else begin
            w_evt_vld = 1'b1;
          end
        end
        ST_EXT: begin
          if (code == SC_F0) begin
            w_state_nxt = ST_EXT_BRK;
          end else begin
            w_evt_vld   = 1'b1;
            w_evt_ext   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_evt_vld   = 1'b1;
          w_evt_brk   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_evt_vld   = 1'b1;
          w_evt_ext   = 1'b1;
          w_evt_brk   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          if (r_skip <= 3'd1) begin
            w_skip_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_skip_nxt = r_skip - 3'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p0: FSM state and the decoded key event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_skip    <= '0;
      r_vld_p0  <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_skip    <= w_skip_nxt;
      r_vld_p0  <= w_evt_vld & w_hit;
      r_seq_err <= w_seq_err;
    end
  end

  always_ff @(posedge clk) begin
    r_idx_p0 <= w_idx;
    r_brk_p0 <= w_evt_brk;
  end

  assign w_mask_p0 = 8'd1 << r_idx_p0;

  // Stage p1: held-key vector and edge pulses; repeats leave state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_state   <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
    end else begin
      r_key_press   <= '0;
      r_key_release <= '0;
      if (r_vld_p0) begin
        if (!r_brk_p0 && !(|(r_key_state & w_mask_p0))) begin
          r_key_state <= r_key_state | w_mask_p0;
          r_key_press <= w_mask_p0;
        end else if (r_brk_p0 && |(r_key_state & w_mask_p0)) begin
          r_key_state   <= r_key_state & ~w_mask_p0;
          r_key_release <= w_mask_p0;
        end
      end
    end
  end

  assign key_state   = r_key_state;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a byte/expectation table plus
// hand-written sequences for back-to-back bytes, timeout and reset.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;
  logic [7:0] key_state, key_press, key_release;
  logic       seq_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] st;
    logic [7:0] pr;
    logic [7:0] rl;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.PREFIX_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .code        (code),
    .code_valid  (code_valid),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .seq_err     (seq_err)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Byte sampled at edge N; returns #1 after edge N+1 when its effect is visible.
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    code = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic [7:0] pr,
                         input logic [7:0] rl);
    chk({tag, "_state"}, key_state, st);
    chk({tag, "_press"}, key_press, pr);
    chk({tag, "_release"}, key_release, rl);
    chk({tag, "_seq_err"}, {7'd0, seq_err}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first_at;

    vecs.push_back('{8'h1A, 8'h10, 8'h10, 8'h00});
    vecs.push_back('{8'h1A, 8'h10, 8'h00, 8'h00});
    vecs.push_back('{8'hF0, 8'h10, 8'h00, 8'h00});
    vecs.push_back('{8'h1A, 8'h00, 8'h00, 8'h10});
    vecs.push_back('{8'hF0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h1A, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'hE0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h75, 8'h01, 8'h01, 8'h00});
    vecs.push_back('{8'hE0, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{8'h74, 8'h09, 8'h08, 8'h00});
    vecs.push_back('{8'hE0, 8'h09, 8'h00, 8'h00});
    vecs.push_back('{8'hF0, 8'h09, 8'h00, 8'h00});
    vecs.push_back('{8'h75, 8'h08, 8'h00, 8'h01});
    vecs.push_back('{8'hE0, 8'h08, 8'h00, 8'h00});
    vecs.push_back('{8'hF0, 8'h08, 8'h00, 8'h00});
    vecs.push_back('{8'h74, 8'h00, 8'h00, 8'h08});
    vecs.push_back('{8'hE1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h14, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h77, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'hE1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'hF0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h14, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'hF0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h77, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'h22, 8'h20, 8'h20, 8'h00});
    vecs.push_back('{8'hAA, 8'h20, 8'h00, 8'h00});
    vecs.push_back('{8'hFA, 8'h20, 8'h00, 8'h00});
    vecs.push_back('{8'h00, 8'h20, 8'h00, 8'h00});
    vecs.push_back('{8'hE0, 8'h20, 8'h00, 8'h00});
    vecs.push_back('{8'h12, 8'h20, 8'h00, 8'h00});
    vecs.push_back('{8'h75, 8'h20, 8'h00, 8'h00});
    vecs.push_back('{8'h12, 8'h60, 8'h40, 8'h00});
    vecs.push_back('{8'hE0, 8'h60, 8'h00, 8'h00});
    vecs.push_back('{8'h1A, 8'h60, 8'h00, 8'h00});
    vecs.push_back('{8'h76, 8'hE0, 8'h80, 8'h00});
    vecs.push_back('{8'hF0, 8'hE0, 8'h00, 8'h00});
    vecs.push_back('{8'h22, 8'hC0, 8'h00, 8'h20});
    vecs.push_back('{8'hF0, 8'hC0, 8'h00, 8'h00});
    vecs.push_back('{8'h76, 8'h40, 8'h00, 8'h80});
    vecs.push_back('{8'hF0, 8'h40, 8'h00, 8'h00});
    vecs.push_back('{8'h12, 8'h00, 8'h00, 8'h40});
    vecs.push_back('{8'hFE, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{8'hFF, 8'h00, 8'h00, 8'h00});

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].code);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr, vecs[i].rl);
    end

    // Back-to-back makes, then back-to-back breaks.
    @(negedge clk);
    code = 8'h76;
    code_valid = 1'b1;
    @(negedge clk);
    code = 8'h1A;
    @(negedge clk);
    code_valid = 1'b0;
    chk_all("b2b_make0", 8'h80, 8'h80, 8'h00);
    @(posedge clk);
    #1;
    chk_all("b2b_make1", 8'h90, 8'h10, 8'h00);

    @(negedge clk);
    code = 8'hF0;
    code_valid = 1'b1;
    @(negedge clk);
    code = 8'h76;
    @(negedge clk);
    code = 8'hF0;
    @(negedge clk);
    code = 8'h1A;
    chk_all("b2b_brk0", 8'h10, 8'h00, 8'h80);
    @(negedge clk);
    code_valid = 1'b0;
    chk_all("b2b_brk1", 8'h10, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    chk_all("b2b_brk2", 8'h00, 8'h00, 8'h10);

    // Prefix timeout: E0 sampled at edge N, expiry seen after edge N+17.
    send(8'hE0);
    pulses = 0;
    first_at = 0;
    for (int j = 2; j <= 40; j++) begin
      @(posedge clk);
      #1;
      if (seq_err) begin
        pulses++;
        if (first_at == 0) first_at = j;
      end
    end
    chk("tmo_pulses", 8'(pulses), 8'd1);
    chk("tmo_edge", 8'(first_at), 8'd17);
    chk("tmo_state", key_state, 8'h00);
    send(8'h75);
    chk_all("tmo_after75", 8'h00, 8'h00, 8'h00);

    // Byte on the exact expiry cycle wins over the timeout.
    send(8'h12);
    chk_all("sim_make", 8'h40, 8'h40, 8'h00);
    @(negedge clk);
    code = 8'hF0;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    code = 8'h12;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("sim_seq_err0", {7'd0, seq_err}, 8'h00);
    @(negedge clk);
    code_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("sim_brk", 8'h00, 8'h00, 8'h40);
    pulses = 0;
    for (int j = 0; j < 25; j++) begin
      @(posedge clk);
      #1;
      if (seq_err) pulses++;
    end
    chk("sim_no_err", 8'(pulses), 8'd0);

    // Asynchronous reset mid-sequence releases keys silently.
    send(8'h12);
    send(8'h1A);
    chk_all("rst_held", 8'h50, 8'h10, 8'h00);
    @(negedge clk);
    code = 8'hE0;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_quiet", 8'h00, 8'h00, 8'h00);
    send(8'h75);
    chk_all("rst_ctx_lost", 8'h00, 8'h00, 8'h00);
    send(8'hE0);
    send(8'h75);
    chk_all("rst_recover", 8'h01, 8'h01, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the scan-code byte stream from the PS/2 receiver (set 2 codes) and turns make, break and prefix sequences into game-control state. It sits between the PS/2 receiver and the player/input logic of the STG core. It resolves the E0, F0 and E1 prefixes and suppresses typematic repeats. It exports a held-key vector plus one-cycle press/release pulses for eight mapped keys.

## Interface

Parameters:

- `PREFIX_TIMEOUT`, default 2_000_000: clk cycles a prefix state may wait for its next byte before abandoning the sequence (20 ms at 100 MHz).

Ports:

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `code` in 8: scan-code byte from the receiver.
- `code_valid` in 1: one-cycle strobe; `code` is sampled when high.
- `key_state` out 8: held keys. Bit mapping: 0 Up (E0 75), 1 Down (E0 72), 2 Left (E0 6B), 3 Right (E0 74), 4 Fire Z (1A), 5 Bomb X (22), 6 Slow LShift (12), 7 Pause Esc (76).
- `key_press` out 8: one-cycle pulse when a bit of `key_state` rises.
- `key_release` out 8: one-cycle pulse when a bit of `key_state` falls.
- `seq_err` out 1: one-cycle pulse when a prefix sequence is abandoned by timeout.

## Operation

- The FSM has five states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (inside an E1 sequence).
- Transitions in IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to SKIP with the skip count set to 7.
  - Any other byte is a make of a non-extended code, and the FSM stays in IDLE.
- Transitions in the prefix states:
  - In EXT: F0 goes to EXT_BRK. Any other byte is an extended make and returns to IDLE.
  - In BRK: any byte is a non-extended break and returns to IDLE.
  - In EXT_BRK: any byte is an extended break and returns to IDLE.
  - In SKIP: each byte decrements the count. The FSM returns to IDLE when the count reaches 0. This discards the full 8-byte Pause/Break sequence, which has no effect on any key.
- Make or break handling:
  - The pair {ext, code} is looked up in the keymap.
  - A make of a mapped key sets its `key_state` bit. A break of a mapped key clears it.
  - Unmapped codes are ignored, including AA, FA, FE, 00, FF, E0 12 and E0 59.
- Typematic handling:
  - A make for a key whose bit is already set changes nothing and produces no pulse.
  - A break for a key whose bit is already clear changes nothing and produces no pulse.
- Prefix timeout:
  - A timer counts clk cycles while the FSM is in EXT, BRK, EXT_BRK or SKIP. It is cleared on every accepted byte and on entry to IDLE.
  - When it reaches `PREFIX_TIMEOUT` with no byte present, the FSM returns to IDLE and `seq_err` pulses. `key_state` is unchanged.
- Simultaneous events: if `code_valid` is high in the cycle the timer expires, the byte wins. It is processed in the current state and no `seq_err` is raised.
- Reset mid-sequence: any prefix context is discarded, the FSM goes to IDLE, and all keys are released silently with no `key_release` pulses.

## Timing

- Reset values: `key_state` = 0, `key_press` = 0, `key_release` = 0, `seq_err` = 0, FSM = IDLE, timer = 0, skip count = 0.
- Latency: a byte sampled at edge N updates `key_state` at edge N+1. Pulses are asserted for exactly the cycle after edge N+1.
- Byte rate: one byte per cycle is accepted; back-to-back `code_valid` is legal. No backpressure; every strobed byte is consumed.
- The timer width is `$clog2(PREFIX_TIMEOUT+1)`. It saturates; it never wraps.
- All outputs are registered.

## Structure

- Shared package `ps2_pkg` holds:
  - scan-code constants (E0, E1, F0 and the eight mapped codes);
  - key index constants 0..7;
  - the FSM state typedef.
- Sub-module `ps2_keymap` is purely combinational. Inputs: `ext`, `code[7:0]`. Outputs: `hit` and `idx[2:0]`. This keeps the FSM independent of the key set.
- A small `ps2_key_decoder` top holds the FSM, the timer, the skip counter and the state/pulse registers.

## Test plan

- Reset, then send 1A → `key_state[4]`=1 and `key_press`=8'h10 for one cycle. Send 1A again → no pulse. Send F0 1A → `key_state`=0 and `key_release`=8'h10.
- Send E0 75, then E0 74, then E0 F0 75 → `key_state` goes 01 → 09 → 08, with the matching press/release pulses.
- Send E1 14 77 E1 F0 14 F0 77, then 22 → only bit 5 is set. No pulses occur during the E1 sequence.
- With `PREFIX_TIMEOUT`=16, send E0 and wait 16 cycles → `seq_err` pulses once. Then send 75 → `key_state[0]` stays 0, because 75 is unmapped as non-extended.
- Send F0 and assert `code_valid` with 12 on the exact expiry cycle → the break of 12 is processed and `seq_err` stays 0. Hold 12 and 1A, then assert `rst_n`=0 mid-stream → `key_state`=0 asynchronously, with no pulses.
